// File: rtl/tq_pkg.sv
// Shared definitions for the rec_tq quantize/dequantize datapath.
package tq_pkg;

  localparam logic [1:0] DCT_4  = 2'd0;
  localparam logic [1:0] DCT_8  = 2'd1;
  localparam logic [1:0] DCT_16 = 2'd2;
  localparam logic [1:0] DCT_32 = 2'd3;

  localparam int COEF_MAX = 32767;
  localparam int COEF_MIN = -32768;

  typedef struct packed {
    logic        inverse;
    logic [1:0]  size;
    logic [15:0] q_data;
    logic [27:0] offset;
    logic [4:0]  shift;
  } q_param_t;

  // Beats per TU at four coefficients per beat.
  function automatic logic [8:0] tu_beats(input logic [1:0] size);
    logic [8:0] beats;
    unique case (size)
      DCT_4:   beats = 9'd4;
      DCT_8:   beats = 9'd16;
      DCT_16:  beats = 9'd64;
      default: beats = 9'd256;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/tq_quant_lane.sv
// One coefficient lane: S1 abs/sign, S2 multiply, S3 offset/shift/saturate.
module tq_quant_lane
  import tq_pkg::*;
#(
  parameter int unsigned COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic                     i_mul_inverse,
  input  logic [15:0]              i_mul_q,
  input  logic                     i_inverse,
  input  logic [27:0]              i_offset,
  input  logic [4:0]               i_shift,
  output logic signed [COEF_W-1:0] o_level,
  output logic                     o_nonzero
);

  localparam int unsigned MW = COEF_W + 17;
  localparam int unsigned SW = MW + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(COEF_MAX);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(COEF_MIN);

  logic signed [COEF_W-1:0] r_coef;
  logic [COEF_W:0]          r_abs;
  logic                     r_zero1;
  logic signed [MW-1:0]     r_mul;
  logic                     r_neg2;
  logic                     r_zero2;

  logic signed [COEF_W:0]   w_coef_x;
  logic [COEF_W:0]          w_abs;
  logic [MW-1:0]            w_fwd_prod;
  logic signed [MW-1:0]     w_coef_ext;
  logic signed [MW-1:0]     w_q_ext;
  logic signed [MW-1:0]     w_inv_prod;
  logic signed [SW-1:0]     w_sum;
  logic signed [SW-1:0]     w_shr;
  logic [COEF_W-1:0]        w_mag;
  logic signed [COEF_W-1:0] w_level;

  // Extra bit so that the most negative coefficient has a representable magnitude.
  assign w_coef_x   = {i_coef[COEF_W-1], i_coef};
  assign w_abs      = i_coef[COEF_W-1] ? -w_coef_x : w_coef_x;
  assign w_fwd_prod = {{(MW-COEF_W-1){1'b0}}, r_abs} * {{(MW-16){1'b0}}, i_mul_q};
  assign w_coef_ext = {{(MW-COEF_W){r_coef[COEF_W-1]}}, r_coef};
  assign w_q_ext    = {{(MW-16){1'b0}}, i_mul_q};
  assign w_inv_prod = w_coef_ext * w_q_ext;
  assign w_sum      = {r_mul[MW-1], r_mul} + {{(SW-28){1'b0}}, i_offset};
  assign w_shr      = w_sum >>> i_shift;

  always_comb begin
    w_mag   = '0;
    w_level = '0;
    if (i_inverse) begin
      if (w_shr > SAT_MAX)      w_level = COEF_W'(COEF_MAX);
      else if (w_shr < SAT_MIN) w_level = COEF_W'(COEF_MIN);
      else                      w_level = w_shr[COEF_W-1:0];
    end else if (!r_zero2) begin
      // Forward sum is never negative, so only the upper bound applies.
      w_mag   = (w_shr > SAT_MAX) ? COEF_W'(COEF_MAX) : w_shr[COEF_W-1:0];
      w_level = r_neg2 ? -w_mag : w_mag;
    end
  end

  assign o_nonzero = |w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coef  <= '0;
      r_abs   <= '0;
      r_zero1 <= 1'b0;
      r_mul   <= '0;
      r_neg2  <= 1'b0;
      r_zero2 <= 1'b0;
      o_level <= '0;
    end else begin
      r_coef  <= i_coef;
      r_abs   <= w_abs;
      r_zero1 <= (i_coef == '0);
      r_mul   <= i_mul_inverse ? w_inv_prod : $signed(w_fwd_prod);
      r_neg2  <= r_coef[COEF_W-1];
      r_zero2 <= r_zero1;
      o_level <= w_level;
    end
  end

endmodule

// File: rtl/tq_quant_pipe.sv
// Three-stage quantize/dequantize pipe with TU framing by beat count and coded-block flag.
module tq_quant_pipe
  import tq_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned COEF_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [LANES*COEF_W-1:0]   i_data,
  input  logic                      i_inverse,
  input  logic [1:0]                i_transize,
  input  logic [15:0]               i_q_data,
  input  logic [27:0]               i_offset,
  input  logic [4:0]                i_shift,
  output logic                      o_valid,
  output logic [LANES*COEF_W-1:0]   o_data,
  output logic                      o_last,
  output logic                      o_cbf
);

  logic [7:0]       r_cnt;
  q_param_t         r_param;
  logic             r_v1, r_l1, r_inv1;
  logic [15:0]      r_q1;
  logic [27:0]      r_off1;
  logic [4:0]       r_sh1;
  logic             r_v2, r_l2, r_inv2;
  logic [27:0]      r_off2;
  logic [4:0]       r_sh2;
  logic             r_acc;

  q_param_t         w_param;
  logic             w_first;
  logic             w_last;
  logic [8:0]       w_beats;
  logic [LANES-1:0] w_nz;
  logic             w_beat_nz;

  // First beat of a TU takes the live inputs; later beats reuse the latched set.
  always_comb begin
    w_first = (r_cnt == 8'd0);
    w_param = w_first ? '{inverse: i_inverse, size: i_transize, q_data: i_q_data,
                          offset: i_offset, shift: i_shift}
                      : r_param;
    w_beats = tu_beats(w_param.size);
    w_last  = (r_cnt == 8'(w_beats - 9'd1));
  end

  assign w_beat_nz = |w_nz;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tq_quant_lane #(
      .COEF_W(COEF_W)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_coef       (i_data[g*COEF_W +: COEF_W]),
      .i_mul_inverse(r_inv1),
      .i_mul_q      (r_q1),
      .i_inverse    (r_inv2),
      .i_offset     (r_off2),
      .i_shift      (r_sh2),
      .o_level      (o_data[g*COEF_W +: COEF_W]),
      .o_nonzero    (w_nz[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_param <= '0;
      r_v1    <= 1'b0;
      r_l1    <= 1'b0;
      r_inv1  <= 1'b0;
      r_q1    <= '0;
      r_off1  <= '0;
      r_sh1   <= '0;
      r_v2    <= 1'b0;
      r_l2    <= 1'b0;
      r_inv2  <= 1'b0;
      r_off2  <= '0;
      r_sh2   <= '0;
      r_acc   <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_cbf   <= 1'b0;
    end else begin
      if (i_valid) begin
        r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
        if (w_first) r_param <= w_param;
      end
      r_v1   <= i_valid;
      r_l1   <= i_valid && w_last;
      r_inv1 <= w_param.inverse;
      r_q1   <= w_param.q_data;
      r_off1 <= w_param.offset;
      r_sh1  <= w_param.shift;
      r_v2   <= r_v1;
      r_l2   <= r_l1;
      r_inv2 <= r_inv1;
      r_off2 <= r_off1;
      r_sh2  <= r_sh1;
      o_valid <= r_v2;
      o_last  <= r_v2 && r_l2;
      o_cbf   <= r_v2 && r_l2 && (r_acc || w_beat_nz);
      // Clearing on the last beat keeps the next TU's first beat from inheriting the flag.
      if (r_v2) r_acc <= r_l2 ? 1'b0 : (r_acc || w_beat_nz);
    end
  end

endmodule

// File: doc/tq_quant_pipe.md
# tq_quant_pipe

Pipelined quantize/dequantize datapath in the rec_tq path. Consumes a coefficient stream plus the per-TU quantization parameter set (`q_data`, `offset`, `shift`) produced by the QP parameter generator. Forward mode produces quantized levels from transform output. Inverse mode produces scaled coefficients for the inverse transform. It frames each TU by beat count and reports a coded-block flag per TU.

## Interface
Parameters:
- `LANES`, 4, coefficients per beat.
- `COEF_W`, 16, signed coefficient/level width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `i_valid`  in  1  input beat valid. No backpressure.
- `i_data`  in  LANES*COEF_W  signed coefficients. Lane 0 is in the LSBs.
- `i_inverse`  in  1  0 = quantize, 1 = dequantize.
- `i_transize`  in  2  TU size: 0 = 4x4, 1 = 8x8, 2 = 16x16, 3 = 32x32.
- `i_q_data`  in  16  scale (forward scale or inverse level-scale<<p), unsigned.
- `i_offset`  in  28  rounding offset, unsigned.
- `i_shift`  in  5  right-shift amount.
- `o_valid`  out  1  output beat valid.
- `o_data`  out  LANES*COEF_W  signed results.
- `o_last`  out  1  high with the final beat of a TU.
- `o_cbf`  out  1  valid with `o_last`. 1 if any output level in the TU is nonzero.

## Operation
- **Beats per TU:** N²/LANES, i.e. 4, 16, 64 or 256 for LANES=4. An 8-bit input beat counter tracks position in the TU.
- **Parameter latch:** on the first beat of a TU (`i_valid` with counter = 0), latch `i_inverse`, `i_transize`, `i_q_data`, `i_offset` and `i_shift`.
  - Input changes to these signals mid-TU are ignored.
  - The latched set travels down the pipeline with each beat, so back-to-back TUs with different parameters are correct.
- **Counter:** increments on each valid beat and wraps to 0 after beat N²/LANES−1. That beat is tagged `last`.
- **Forward, per lane:**
  - `a = |c|` (17 bits, so −32768 is handled).
  - `m = a*q_data` (33 bits).
  - `s = m + offset` (34 bits).
  - `l = s >> shift`, saturated to 32767, then the sign of `c` is reapplied.
  - `c = 0` gives 0.
- **Inverse, per lane:**
  - `m = c*$signed({1'b0,q_data})` (33-bit signed).
  - `s = m + offset` (34-bit signed).
  - `l = s >>> shift` (arithmetic), saturated to [−32768, 32767].
- **CBF:** an accumulator ORs "any lane nonzero" over the output beats of a TU, including the last beat.
  - `o_cbf` = accumulator OR current beat, presented on the `o_last` beat.
  - The accumulator clears after the `o_last` beat.
- **Invalid input cycles:** cycles with `i_valid` low are bubbles. The counter holds and bubbles propagate as `o_valid` = 0.

## Timing
- **Pipeline (latency 3 cycles, throughput 1 beat/cycle):**
  - S1: register input, absolute value/sign, parameters, `last`.
  - S2: multiply.
  - S3: add, shift, saturate, sign restore, CBF.
- An input beat at cycle t appears at the outputs at t+3. `o_last` and `o_cbf` are aligned to that beat.
- **Reset:**
  - All outputs are 0: `o_valid`, `o_data`, `o_last`, `o_cbf`.
  - The beat counter, CBF accumulator and every pipeline valid bit are cleared.
- **Reset mid-TU:** in-flight beats are discarded, with no `o_valid` for them. The first valid beat after reset starts a new TU.
- **Simultaneous events:** the last beat of one TU and the first beat of the next on consecutive cycles must not merge CBF. The accumulator clear takes priority, and the new TU's first beat seeds a fresh accumulator value.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- **Shared package `tq_pkg`:**
  - `DCT_4`, `DCT_8`, `DCT_16`, `DCT_32` size encodings.
  - A `tu_beats(size)` function.
  - A `q_param_t` struct holding inverse, size, q_data, offset and shift.
  - `COEF_MAX` / `COEF_MIN` constants.
- **Sub-module `tq_quant_lane`:** one lane covering S1–S3 arithmetic, instantiated LANES times by generate.
- **Top:** owns the counter, parameter latch/propagation, valid/last pipeline and CBF.

## Test plan
- Forward 4x4, `q_data`=26214, `offset`=175104, `shift`=19, lanes {100, −100, 0, 1}: output t+3 is {5, −5, 0, 0}.
- Inverse 4x4, `q_data`=40, `offset`=1, `shift`=1, lanes {5, −5, 0, 1}: output is {100, −100, 0, 20}.
- Inverse 32x32, `q_data`=18432, `offset`=8, `shift`=4, lanes {32767, −32768, 1, −1}:
  - Required output: {32767, −32768, 1152, −1152}.
  - The first two lanes confirm saturation.
- Framing, back-to-back with no gaps:
  - Stimulus: 16 beats of 8x8, then 4 beats of 4x4 with different parameters.
  - `o_last` on output beats 16 and 20.
  - Each TU uses its own latched parameters.
  - `o_cbf` = 1 for the first TU (one nonzero beat only) and 0 for the all-zero second TU.
- Bubbles: a 4x4 TU with `i_valid` low every other cycle still gives `o_last` on the 4th valid output, and the counter holds during bubbles.
- Reset mid-TU: 2 beats, then `rst` high for 1 cycle, then 4 beats. Required response:
  - No output for the first 2 beats.
  - One TU whose `o_last` is on the 4th output after reset.
  - All outputs 0 during the reset cycle.
